sync_fifo_rd_stream: RTL and testbench

- Read-side consumer for the pointer-based synchronous FIFO (registered data_out, one-cycle read latency).
- Drives the FIFO's rd_en from its empty flag and re-times the returned words into a valid/ready stream through a 2-entry output buffer.
- Sits between the FIFO read port and any downstream consumer that may stall.
- Sustains one word per clock when downstream is always ready, and never over-reads.

---
 rtl/sync_fifo_rd_stream.sv | 95 +++++++++
 tb/tb_sync_fifo_rd_stream.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_rd_stream.sv
// sync_fifo_rd_stream
//   Read-side consumer for a synchronous FIFO with registered data_out (one-cycle read latency).
//   Issues FIFO reads from the empty flag and re-times the returned words into a valid/ready
//   stream through a 2-entry buffer. Sustains one word per clock and never over-reads.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO data_out, valid in the cycle after a granted read
//   fifo_rd_en  read request to FIFO (combinational)
//   m_valid     output word available
//   m_ready     downstream accepts word
//   m_data      output word (buffer head)
//   word_cnt    count of completed m_valid && m_ready handshakes (wraps)
//   busy        buffer non-empty or a read is in flight
module sync_fifo_rd_stream #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_rd_en,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [CNT_WIDTH-1:0]  word_cnt,
   output logic                  busy
);

   logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
   logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
   logic                  wr_ptr_q, wr_ptr_d;
   logic                  rd_ptr_q, rd_ptr_d;
   logic [1:0]            occ_q, occ_d;
   logic                  inflight_q, inflight_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  pop;
   logic [2:0]            occ_after;

   always_comb begin
      m_valid = (occ_q != 2'd0);
      m_data  = rd_ptr_q ? buf1_q : buf0_q;
      busy    = (occ_q != 2'd0) || inflight_q;
      pop     = m_valid && m_ready;

      // Occupancy after this edge. pop implies occ_q >= 1, so this never goes negative.
      occ_after = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

      // rst_n gates the request so nothing is asked of the FIFO while held in reset.
      fifo_rd_en = rst_n && !fifo_empty && (occ_after < 3'd2);
      inflight_d = fifo_rd_en;

      buf0_d   = buf0_q;
      buf1_d   = buf1_q;
      wr_ptr_d = wr_ptr_q;
      if (inflight_q) begin
         if (wr_ptr_q) begin
            buf1_d = fifo_data;
         end else begin
            buf0_d = fifo_data;
         end
         wr_ptr_d = ~wr_ptr_q;
      end

      rd_ptr_d = pop ? ~rd_ptr_q : rd_ptr_q;
      cnt_d    = pop ? cnt_q + 1'b1 : cnt_q;
      occ_d    = occ_after[1:0];
   end

   assign word_cnt = cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf0_q     <= '0;
         buf1_q     <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         occ_q      <= 2'd0;
         inflight_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         buf0_q     <= buf0_d;
         buf1_q     <= buf1_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
         inflight_q <= inflight_d;
         cnt_q      <= cnt_d;
      end
   end

endmodule

// File: tb/tb_sync_fifo_rd_stream.sv
// Testbench for sync_fifo_rd_stream: drives a behavioural registered-output FIFO and checks the
// resulting stream against the words written. A second instance with CNT_WIDTH=4 runs in
// lock-step on the same inputs to observe counter wrap.
module tb_sync_fifo_rd_stream;

   logic        clk        = 1'b0;
   logic        rst_n      = 1'b1;
   logic        fifo_rst_n = 1'b1;
   logic        m_ready    = 1'b0;
   logic        wr_en      = 1'b0;
   logic [7:0]  wr_data    = 8'h00;

   logic        fifo_empty;
   logic [7:0]  fifo_data;
   logic        fifo_rd_en;
   logic        m_valid;
   logic [7:0]  m_data;
   logic [15:0] word_cnt;
   logic        busy;

   logic        rd_en4;
   logic        m_valid4;
   logic [7:0]  m_data4;
   logic [3:0]  word_cnt4;
   logic        busy4;

   int          checks = 0;
   int          errors = 0;
   int          rd_pulses = 0;
   int          pops = 0;
   int          max_out = 0;
   bit          rd_empty_seen = 1'b0;
   logic [7:0]  got[$];
   logic [7:0]  exp_q[$];

   always #5 clk = ~clk;

   sync_fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_rd_en (fifo_rd_en),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .word_cnt   (word_cnt),
      .busy       (busy)
   );

   sync_fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
      .clk        (clk),
      .rst_n      (rst_n),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_rd_en (rd_en4),
      .m_valid    (m_valid4),
      .m_ready    (m_ready),
      .m_data     (m_data4),
      .word_cnt   (word_cnt4),
      .busy       (busy4)
   );

   // Behavioural FIFO: registered data_out, word appears the cycle after a granted read.
   logic [7:0] mem [256];
   logic [7:0] fwp_q, frp_q;
   assign fifo_empty = (fwp_q == frp_q);

   always @(posedge clk or negedge fifo_rst_n) begin
      if (!fifo_rst_n) begin
         fwp_q     <= 8'd0;
         frp_q     <= 8'd0;
         fifo_data <= 8'd0;
      end else begin
         if (wr_en) begin
            mem[fwp_q] <= wr_data;
            fwp_q      <= fwp_q + 8'd1;
         end
         if (fifo_rd_en && !fifo_empty) begin
            fifo_data <= mem[frp_q];
            frp_q     <= frp_q + 8'd1;
         end
      end
   end

   // Observer: records accepted beats and read grants as seen at each edge.
   always @(posedge clk) begin
      if (rst_n) begin
         if (fifo_rd_en && fifo_empty) rd_empty_seen = 1'b1;
         if (fifo_rd_en && !fifo_empty) rd_pulses++;
         if (m_valid && m_ready) begin
            got.push_back(m_data);
            pops++;
         end
         if (rd_pulses - pops > max_out) max_out = rd_pulses - pops;
      end
   end

   // Leaves the DUT held in reset with an empty FIFO and cleared bookkeeping.
   task automatic tb_reset();
      @(negedge clk);
      rst_n      = 1'b0;
      fifo_rst_n = 1'b0;
      m_ready    = 1'b0;
      wr_en      = 1'b0;
      @(negedge clk);
      fifo_rst_n = 1'b1;
      got.delete();
      exp_q.delete();
      rd_pulses     = 0;
      pops          = 0;
      max_out       = 0;
      rd_empty_seen = 1'b0;
   endtask

   task automatic push(input logic [7:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      exp_q.push_back(d);
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic push_test1_words();
      push(8'h24); push(8'h81); push(8'h09); push(8'h63);
      push(8'h0D); push(8'h8D); push(8'h65); push(8'h12);
   endtask

   task automatic test_reset();
      tb_reset();
      push(8'h11); push(8'h22); push(8'h33);
      checks++;
      if (fifo_rd_en !== 1'b0) begin
         errors++; $display("FAIL reset_rd_en: got %b, expected 0", fifo_rd_en);
      end
      checks++;
      if (m_valid !== 1'b0) begin
         errors++; $display("FAIL reset_m_valid: got %b, expected 0", m_valid);
      end
      checks++;
      if (m_data !== 8'h00) begin
         errors++; $display("FAIL reset_m_data: got %h, expected 00", m_data);
      end
      checks++;
      if (word_cnt !== 16'd0) begin
         errors++; $display("FAIL reset_word_cnt: got %0d, expected 0", word_cnt);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL reset_busy: got %b, expected 0", busy);
      end
   endtask

   task automatic test_stream();
      tb_reset();
      push_test1_words();
      m_ready = 1'b1;
      rst_n   = 1'b1;
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0) begin
         errors++; $display("FAIL stream_latency_c1: m_valid got %b, expected 0", m_valid);
      end
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (m_valid !== 1'b1 || m_data !== exp_q[i]) begin
            errors++;
            $display("FAIL stream_beat%0d: got valid=%b data=%h, expected valid=1 data=%h",
                     i, m_valid, m_data, exp_q[i]);
         end
         @(negedge clk);
      end
      checks++;
      if (m_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL stream_idle: got valid=%b busy=%b, expected 0 0", m_valid, busy);
      end
      checks++;
      if (word_cnt !== 16'd8) begin
         errors++; $display("FAIL stream_word_cnt: got %0d, expected 8", word_cnt);
      end
      checks++;
      if (rd_empty_seen !== 1'b0) begin
         errors++; $display("FAIL stream_rd_when_empty: got %b, expected 0", rd_empty_seen);
      end
   endtask

   task automatic test_stall();
      tb_reset();
      push_test1_words();
      m_ready = 1'b0;
      rst_n   = 1'b1;
      @(negedge clk);
      @(negedge clk);
      for (int k = 0; k < 9; k++) begin
         checks++;
         if (m_valid !== 1'b1 || m_data !== 8'h24) begin
            errors++;
            $display("FAIL stall_hold%0d: got valid=%b data=%h, expected valid=1 data=24",
                     k, m_valid, m_data);
         end
         @(negedge clk);
      end
      checks++;
      if (rd_pulses !== 2) begin
         errors++; $display("FAIL stall_rd_pulses: got %0d, expected 2", rd_pulses);
      end
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (m_valid !== 1'b1 || m_data !== exp_q[i]) begin
            errors++;
            $display("FAIL stall_drain%0d: got valid=%b data=%h, expected valid=1 data=%h",
                     i, m_valid, m_data, exp_q[i]);
         end
         @(negedge clk);
      end
      checks++;
      if (m_valid !== 1'b0 || word_cnt !== 16'd8) begin
         errors++;
         $display("FAIL stall_end: got valid=%b cnt=%0d, expected valid=0 cnt=8", m_valid, word_cnt);
      end
   endtask

   task automatic test_toggle();
      tb_reset();
      for (int i = 0; i < 8; i++) push(8'(8'hA0 + i * 7));
      rst_n = 1'b1;
      for (int cyc = 0; cyc < 60; cyc++) begin
         m_ready = (cyc % 2 == 0);
         @(negedge clk);
         if (pops == 8) break;
      end
      m_ready = 1'b0;
      checks++;
      if (got.size() != exp_q.size()) begin
         errors++; $display("FAIL toggle_count: got %0d beats, expected %0d", got.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         checks++;
         if (got[i] !== exp_q[i]) begin
            errors++; $display("FAIL toggle_word%0d: got %h, expected %h", i, got[i], exp_q[i]);
         end
      end
      checks++;
      if (word_cnt !== 16'd8) begin
         errors++; $display("FAIL toggle_word_cnt: got %0d, expected 8", word_cnt);
      end
      checks++;
      if (max_out > 2) begin
         errors++; $display("FAIL toggle_occupancy: got %0d outstanding, expected <= 2", max_out);
      end
   endtask

   task automatic test_back_to_back();
      int gaps;
      bit seen;
      gaps = 0;
      seen = 1'b0;
      tb_reset();
      for (int i = 0; i < 4; i++) push(8'(8'h40 + i));
      m_ready = 1'b1;
      rst_n   = 1'b1;
      for (int i = 0; i < 20; i++) begin
         wr_en   = 1'b1;
         wr_data = 8'($urandom);
         exp_q.push_back(wr_data);
         @(negedge clk);
         if (m_valid) seen = 1'b1;
         else if (seen && pops < 24) gaps++;
      end
      wr_en = 1'b0;
      for (int cyc = 0; cyc < 40 && pops < 24; cyc++) begin
         @(negedge clk);
         if (m_valid) seen = 1'b1;
         else if (seen && pops < 24) gaps++;
      end
      checks++;
      if (got.size() != exp_q.size()) begin
         errors++; $display("FAIL b2b_count: got %0d beats, expected %0d", got.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         checks++;
         if (got[i] !== exp_q[i]) begin
            errors++; $display("FAIL b2b_word%0d: got %h, expected %h", i, got[i], exp_q[i]);
         end
      end
      checks++;
      if (gaps != 0) begin
         errors++; $display("FAIL b2b_bubbles: got %0d idle cycles, expected 0", gaps);
      end
   endtask

   task automatic test_async_reset();
      tb_reset();
      push_test1_words();
      m_ready = 1'b0;
      rst_n   = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1 || busy !== 1'b1 || m_data !== 8'h24) begin
         errors++;
         $display("FAIL areset_pre: got valid=%b busy=%b data=%h, expected 1 1 24",
                  m_valid, busy, m_data);
      end
      #2;
      rst_n      = 1'b0;
      fifo_rst_n = 1'b0;
      #1;
      checks++;
      if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0 || m_data !== 8'h00 || word_cnt !== 16'd0 ||
          busy !== 1'b0) begin
         errors++;
         $display("FAIL areset_outputs: got rd=%b valid=%b data=%h cnt=%0d busy=%b, expected all 0",
                  fifo_rd_en, m_valid, m_data, word_cnt, busy);
      end
      @(negedge clk);
      fifo_rst_n = 1'b1;
      got.delete();
      exp_q.delete();
      rd_pulses = 0;
      pops      = 0;
      @(negedge clk);
      rst_n   = 1'b1;
      m_ready = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (m_valid !== 1'b0 || rd_pulses != 0 || got.size() != 0) begin
         errors++;
         $display("FAIL areset_stale: got valid=%b reads=%0d beats=%0d, expected 0 0 0",
                  m_valid, rd_pulses, got.size());
      end
      push(8'h5A);
      push(8'h3C);
      repeat (5) @(negedge clk);
      checks++;
      if (got.size() != 2) begin
         errors++; $display("FAIL areset_after_count: got %0d beats, expected 2", got.size());
      end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         checks++;
         if (got[i] !== exp_q[i]) begin
            errors++; $display("FAIL areset_after_word%0d: got %h, expected %h", i, got[i], exp_q[i]);
         end
      end
      checks++;
      if (word_cnt !== 16'd2) begin
         errors++; $display("FAIL areset_word_cnt: got %0d, expected 2", word_cnt);
      end
   endtask

   task automatic test_wrap();
      tb_reset();
      for (int i = 0; i < 17; i++) push(8'(i * 3 + 1));
      m_ready = 1'b1;
      rst_n   = 1'b1;
      for (int cyc = 0; cyc < 60 && pops < 17; cyc++) @(negedge clk);
      checks++;
      if (got.size() != 17) begin
         errors++; $display("FAIL wrap_count: got %0d beats, expected 17", got.size());
      end
      checks++;
      if (word_cnt4 !== 4'd1) begin
         errors++; $display("FAIL wrap_cnt4: got %0d, expected 1", word_cnt4);
      end
      checks++;
      if (word_cnt !== 16'd17) begin
         errors++; $display("FAIL wrap_cnt16: got %0d, expected 17", word_cnt);
      end
      checks++;
      if (rd_empty_seen !== 1'b0) begin
         errors++; $display("FAIL wrap_rd_when_empty: got %b, expected 0", rd_empty_seen);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_toggle();
      test_back_to_back();
      test_async_reset();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
